accum_drain: RTL and testbench

ACCUM_DRAIN -- requirements
Module: accum_drain

---
 rtl/accum_drain.sv | 113 +++++++++++
 tb/tb_accum_drain.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/accum_drain.sv
// Snapshots a packed accumulator array and streams it out entry by entry,
// saturated to OW bits. Define ACCUM_DRAIN_RELU_EN to clamp negative entries to zero.
module accum_drain #(
  parameter int N  = 144,
  parameter int W  = 20,
  parameter int OW = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [W*N-1:0]   accum_in,
  input  logic             start,
  input  logic             o_ready,
  output logic             o_valid,
  output logic [OW-1:0]    o_data,
  output logic [7:0]       o_idx,
  output logic             o_last,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    DONE
  } state_t;

  localparam logic [7:0] K_LAST = 8'(N - 1);

  state_t           state;
  state_t           state_next;
  logic [7:0]       k;
  logic [7:0]       k_next;
  logic             snap_load;
  logic [W*N-1:0]   snapshot;
  logic [W-1:0]     entry;
  logic [OW-1:0]    sat_val;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      k     <= '0;
    end else begin
      state <= state_next;
      k     <= k_next;
    end
  end

  // Snapshot is deliberately not reset; outputs are masked whenever o_valid is low.
  always_ff @(posedge clk) begin
    if (snap_load) begin
      snapshot <= accum_in;
    end
  end

  always_comb begin
    state_next = state;
    k_next     = k;
    snap_load  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          snap_load  = 1'b1;
          k_next     = '0;
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (o_ready) begin
          if (k == K_LAST) begin
            k_next     = '0;
            state_next = DONE;
          end else begin
            k_next = k + 8'd1;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Entry 0 lives in the most significant slice of the snapshot.
  always_comb begin
    entry = snapshot[(N - 1 - int'(k)) * W +: W];
  end

  // Out of range when the bits above the OW-1 sign position disagree with the sign.
  always_comb begin
    sat_val = entry[OW-1:0];
    if (entry[W-1:OW-1] != {(W-OW+1){entry[W-1]}}) begin
      sat_val = entry[W-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
    end
`ifdef ACCUM_DRAIN_RELU_EN
    if (entry[W-1]) begin
      sat_val = '0;
    end
`endif
  end

  always_comb begin
    o_valid = (state == DRAIN);
    o_data  = o_valid ? sat_val : '0;
    o_idx   = o_valid ? k : '0;
    o_last  = o_valid && (k == K_LAST);
    busy    = (state != IDLE);
    done    = (state == DONE);
  end

endmodule

// File: tb/tb_accum_drain.sv
// Scoreboard bench for accum_drain: stimulus pushes expected beats, a negedge
// monitor pops and compares them on every handshake.
module tb_accum_drain;

  localparam int N  = 144;
  localparam int W  = 20;
  localparam int OW = 16;

  typedef struct {
    logic [OW-1:0] data;
    logic [7:0]    idx;
    logic          last;
  } exp_t;

  logic             clk;
  logic             reset;
  logic [W*N-1:0]   accum_in;
  logic             start;
  logic             o_ready;
  logic             o_valid;
  logic [OW-1:0]    o_data;
  logic [7:0]       o_idx;
  logic             o_last;
  logic             busy;
  logic             done;

  exp_t sb[$];
  int   checks;
  int   failures;

  accum_drain #(.N(N), .W(W), .OW(OW)) dut (
    .clk      (clk),
    .reset    (reset),
    .accum_in (accum_in),
    .start    (start),
    .o_ready  (o_ready),
    .o_valid  (o_valid),
    .o_data   (o_data),
    .o_idx    (o_idx),
    .o_last   (o_last),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one sampled edge; afterwards the first beat should be visible.
  task automatic applyStimulus();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pushExp(input logic [OW-1:0] data, input int idx);
    exp_t e;
    e.data = data;
    e.idx  = 8'(idx);
    e.last = (idx == N - 1);
    sb.push_back(e);
  endtask

  task automatic loadRamp();
    for (int k = 0; k < N; k++) begin
      accum_in[(N - 1 - k) * W +: W] = 20'(k + 1);
    end
  endtask

  // Expects o_ready=1 throughout; checks one beat per cycle with no bubbles.
  task automatic runBeats(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      checkOutput("beat_valid", 32'(o_valid), 32'd1);
      checkOutput("beat_idx", 32'(o_idx), 32'(i));
      checkOutput("beat_last", 32'(o_last), 32'(i == N - 1));
      tick();
    end
  endtask

  task automatic checkDoneThenIdle();
    checkOutput("done_pulse", 32'(done), 32'd1);
    checkOutput("done_valid", 32'(o_valid), 32'd0);
    checkOutput("done_busy", 32'(busy), 32'd1);
    tick();
    checkOutput("idle_done", 32'(done), 32'd0);
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_valid"}, 32'(o_valid), 32'd0);
    checkOutput({tag, "_data"}, 32'(o_data), 32'd0);
    checkOutput({tag, "_idx"}, 32'(o_idx), 32'd0);
    checkOutput({tag, "_last"}, 32'(o_last), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
  endtask

  always @(negedge clk) begin
    if (reset && o_valid && o_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_beat actual idx=%0d required none", o_idx);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("sb_data", 32'(o_data), 32'(e.data));
        checkOutput("sb_idx", 32'(o_idx), 32'(e.idx));
        checkOutput("sb_last", 32'(o_last), 32'(e.last));
      end
    end
  end

  initial begin
    logic [OW-1:0] held;
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    start    = 1'b0;
    o_ready  = 1'b1;
    accum_in = '0;
    tick();
    tick();
    checkIdleOutputs("reset");

    // Ramp drain, started on the very first cycle out of reset.
    $display("[TB] ramp drain");
    loadRamp();
    for (int k = 0; k < N; k++) pushExp(16'(k + 1), k);
    reset = 1'b1;
    applyStimulus();
    runBeats(0, N - 1);
    checkDoneThenIdle();

    // Saturation of the top three entries.
    $display("[TB] saturation");
    accum_in = '0;
    accum_in[(N - 1) * W +: W] = 20'h7FFFF;
    accum_in[(N - 2) * W +: W] = 20'h80000;
    accum_in[(N - 3) * W +: W] = 20'h00123;
    pushExp(16'h7FFF, 0);
`ifdef ACCUM_DRAIN_RELU_EN
    pushExp(16'h0000, 1);
`else
    pushExp(16'h8000, 1);
`endif
    pushExp(16'h0123, 2);
    for (int k = 3; k < N; k++) pushExp(16'h0000, k);
    applyStimulus();
    runBeats(0, N - 1);
    checkDoneThenIdle();

    // Backpressure at k=10 for five cycles.
    $display("[TB] backpressure");
    loadRamp();
    for (int k = 0; k < N; k++) pushExp(16'(k + 1), k);
    applyStimulus();
    runBeats(0, 9);
    o_ready = 1'b0;
    held = o_data;
    checkOutput("bp_first_data", 32'(held), 32'd11);
    for (int c = 0; c < 5; c++) begin
      tick();
      checkOutput("bp_hold_data", 32'(o_data), 32'd11);
      checkOutput("bp_hold_idx", 32'(o_idx), 32'd10);
      checkOutput("bp_hold_valid", 32'(o_valid), 32'd1);
    end
    o_ready = 1'b1;
    tick();
    checkOutput("bp_resume_idx", 32'(o_idx), 32'd11);
    runBeats(11, N - 1);
    checkDoneThenIdle();

    // Start during DRAIN with new data must be ignored.
    $display("[TB] start during drain");
    loadRamp();
    for (int k = 0; k < N; k++) pushExp(16'(k + 1), k);
    applyStimulus();
    runBeats(0, 19);
    accum_in = '1;
    applyStimulus();
    runBeats(21, N - 1);
    checkDoneThenIdle();

    // Reset asserted while k=50 is presented, then a fresh drain.
    $display("[TB] reset mid-drain");
    loadRamp();
    for (int k = 0; k < 50; k++) pushExp(16'(k + 1), k);
    applyStimulus();
    runBeats(0, 49);
    checkOutput("pre_reset_idx", 32'(o_idx), 32'd50);
    o_ready = 1'b0;
    reset = 1'b0;
    tick();
    checkIdleOutputs("midreset");
    checkOutput("midreset_sb_empty", 32'(sb.size()), 32'd0);
    reset = 1'b1;
    o_ready = 1'b1;
    for (int k = 0; k < N; k++) pushExp(16'(k + 1), k);
    applyStimulus();
    runBeats(0, N - 1);
    checkDoneThenIdle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
